// File: rtl/pipelined_mux_tree.sv
// N-to-1 multiplexer built as a registered binary tree: one register level per select bit.
// Optional Out_parity output is compiled in when PIPELINED_MUX_PARITY_EN is defined.
module pipelined_mux_tree #(
    parameter int WIDTH    = 8,
    parameter int SEL_BITS = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [(2**SEL_BITS)*WIDTH-1:0]    In,
    input  logic [SEL_BITS-1:0]               Selector,
    input  logic                              Valid_in,
    input  logic                              En,
    input  logic                              Mode,
    output logic [WIDTH-1:0]                  Out,
    output logic                              Out_valid,
    output logic [SEL_BITS-1:0]               Out_sel
`ifdef PIPELINED_MUX_PARITY_EN
    ,
    output logic                              Out_parity
`endif
);

    localparam int N = 2**SEL_BITS;

    logic [SEL_BITS-1:0] scan_reg;
    logic [SEL_BITS-1:0] eff_sel;
    logic                accept;

    // Level 0 is the live input; level k (k >= 1) is the stage-k register bank.
    logic [N*WIDTH-1:0]  lvl_data  [SEL_BITS+1];
    logic [SEL_BITS-1:0] lvl_tag   [SEL_BITS+1];
    logic                lvl_valid [SEL_BITS+1];
`ifdef PIPELINED_MUX_PARITY_EN
    logic                lvl_par   [SEL_BITS+1];
`endif

    assign eff_sel      = Mode ? scan_reg : Selector;
    assign accept       = En && Valid_in;
    assign lvl_data[0]  = In;
    assign lvl_tag[0]   = eff_sel;
    assign lvl_valid[0] = Valid_in;
`ifdef PIPELINED_MUX_PARITY_EN
    assign lvl_par[0]   = ^In[eff_sel*WIDTH +: WIDTH];
`endif

    // The scan index is kept while Mode=0 so auto-scan resumes where it stopped.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_reg <= '0;
        end else if (accept && Mode) begin
            scan_reg <= scan_reg + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi <= SEL_BITS; gi++) begin : g_stage
            localparam int CNT = N >> gi;

            logic [N*WIDTH-1:0]  data_reg;
            logic [N*WIDTH-1:0]  data_next;
            logic [SEL_BITS-1:0] tag_reg;
            logic                valid_reg;

            // Pair neighbours from the previous level using the tag bit that belongs to this level.
            always_comb begin
                data_next = '0;
                for (int j = 0; j < CNT; j++) begin
                    data_next[j*WIDTH +: WIDTH] = lvl_tag[gi-1][gi-1]
                        ? lvl_data[gi-1][(2*j+1)*WIDTH +: WIDTH]
                        : lvl_data[gi-1][(2*j)*WIDTH +: WIDTH];
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    data_reg  <= '0;
                    tag_reg   <= '0;
                    valid_reg <= 1'b0;
                end else if (En) begin
                    data_reg  <= data_next;
                    tag_reg   <= lvl_tag[gi-1];
                    valid_reg <= lvl_valid[gi-1];
                end
            end

            assign lvl_data[gi]  = data_reg;
            assign lvl_tag[gi]   = tag_reg;
            assign lvl_valid[gi] = valid_reg;

`ifdef PIPELINED_MUX_PARITY_EN
            logic par_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    par_reg <= 1'b0;
                end else if (En) begin
                    par_reg <= lvl_par[gi-1];
                end
            end
            assign lvl_par[gi] = par_reg;
`endif
        end
    endgenerate

    assign Out       = lvl_data[SEL_BITS][WIDTH-1:0];
    assign Out_valid = lvl_valid[SEL_BITS];
    assign Out_sel   = lvl_tag[SEL_BITS];
`ifdef PIPELINED_MUX_PARITY_EN
    assign Out_parity = lvl_par[SEL_BITS];
`endif

endmodule

// File: tb/tb_pipelined_mux_tree.sv
// Directed bench for pipelined_mux_tree (WIDTH=8, SEL_BITS=3, channel c carries 8'h11*c).
module tb_pipelined_mux_tree;

    localparam int WIDTH    = 8;
    localparam int SEL_BITS = 3;
    localparam int N        = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N*WIDTH-1:0]   in_bus;
    logic [SEL_BITS-1:0]  selector;
    logic                 valid_in;
    logic                 en;
    logic                 mode;
    logic [WIDTH-1:0]     out;
    logic                 out_valid;
    logic [SEL_BITS-1:0]  out_sel;

    int checks = 0;
    int errors = 0;

    pipelined_mux_tree #(.WIDTH(WIDTH), .SEL_BITS(SEL_BITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .In        (in_bus),
        .Selector  (selector),
        .Valid_in  (valid_in),
        .En        (en),
        .Mode      (mode),
        .Out       (out),
        .Out_valid (out_valid),
        .Out_sel   (out_sel)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_channels;
        for (int c = 0; c < N; c++) in_bus[c*WIDTH +: WIDTH] = 8'(17 * c);
    endtask

    task automatic test_reset;
        reset    = 1'b1;
        in_bus   = {$urandom, $urandom};
        selector = 3'($urandom);
        valid_in = 1'b1;
        en       = 1'($urandom);
        mode     = 1'($urandom);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({out_valid, out_sel, out} !== {1'b0, 3'd0, 8'h00}) begin
                errors++;
                $display("FAIL reset[%0d]: got valid=%b sel=%0d out=%h, want valid=0 sel=0 out=00", i, out_valid, out_sel, out);
            end else $display("reset[%0d] ok", i);
        end
        reset = 1'b0; valid_in = 1'b0; en = 1'b1; mode = 1'b0;
        load_channels();
    endtask

    task automatic test_single;
        selector = 3'd5; valid_in = 1'b1;
        tick();                                    // now cycle t+1
        valid_in = 1'b0;
        in_bus   = ~in_bus;                        // must not affect the request in flight
        for (int c = 1; c <= 4; c++) begin
            logic [11:0] want;
            want = (c == 3) ? {1'b1, 3'd5, 8'h55} : 12'h000;
            checks++;
            if (c == 3 ? ({out_valid, out_sel, out} !== want) : (out_valid !== 1'b0)) begin
                errors++;
                $display("FAIL single t+%0d: got valid=%b sel=%0d out=%h, want valid=%b sel=%0d out=%h",
                         c, out_valid, out_sel, out, want[11], want[10:8], want[7:0]);
            end else $display("single t+%0d ok valid=%b out=%h", c, out_valid, out);
            if (c < 4) tick();
        end
        load_channels();
    endtask

    task automatic test_back_to_back;
        for (int c = 0; c < 12; c++) begin
            valid_in = (c < 8);
            selector = 3'(c);
            tick();                                // now cycle c+1
            if (c + 1 >= 3 && c + 1 <= 11) begin
                logic [11:0] want;
                int k;
                k    = c - 2;
                want = (k < 8) ? {1'b1, 3'(k), 8'(17 * k)} : 12'h000;
                checks++;
                if ((k < 8) ? ({out_valid, out_sel, out} !== want) : (out_valid !== 1'b0)) begin
                    errors++;
                    $display("FAIL b2b[%0d]: got valid=%b sel=%0d out=%h, want valid=%b sel=%0d out=%h",
                             k, out_valid, out_sel, out, want[11], want[10:8], want[7:0]);
                end else $display("b2b[%0d] ok valid=%b sel=%0d out=%h", k, out_valid, out_sel, out);
            end
        end
    endtask

    task automatic test_stall;
        logic [11:0] want [7];
        // index = cycle offset from t+1 .. t+7
        want[0] = {1'b1, 3'd4, 8'h44};  // t+1 (stall starts this cycle)
        want[1] = {1'b1, 3'd4, 8'h44};  // t+2 held
        want[2] = {1'b1, 3'd4, 8'h44};  // t+3 held
        want[3] = {1'b1, 3'd6, 8'h66};  // t+4
        want[4] = {1'b1, 3'd2, 8'h22};  // t+5
        want[5] = 12'h000;              // t+6 bubble
        want[6] = 12'h000;              // t+7 bubble
        valid_in = 1'b1;
        selector = 3'd4; tick();
        selector = 3'd6; tick();
        selector = 3'd2; tick();                   // now cycle t+1
        for (int c = 0; c < 7; c++) begin
            en       = !(c == 0 || c == 1);
            valid_in = (c < 2);                    // requests offered during the stall must be ignored
            selector = 3'd7;
            checks++;
            if (want[c][11] ? ({out_valid, out_sel, out} !== want[c]) : (out_valid !== 1'b0)) begin
                errors++;
                $display("FAIL stall t+%0d: got valid=%b sel=%0d out=%h, want valid=%b sel=%0d out=%h",
                         c + 1, out_valid, out_sel, out, want[c][11], want[c][10:8], want[c][7:0]);
            end else $display("stall t+%0d ok valid=%b sel=%0d out=%h", c + 1, out_valid, out_sel, out);
            if (c < 6) tick();
        end
        en = 1'b1; valid_in = 1'b0;
    endtask

    task automatic test_autoscan;
        logic [2:0] exp_sel [13];
        for (int i = 0; i < 10; i++) exp_sel[i] = 3'(i % 8);
        exp_sel[10] = 3'd5; exp_sel[11] = 3'd6; exp_sel[12] = 3'd2;
        reset = 1'b1; valid_in = 1'b0;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 15; c++) begin
            valid_in = (c < 13);
            mode     = !(c == 10 || c == 11);
            selector = (c == 10) ? 3'd5 : (c == 11) ? 3'd6 : 3'd3;
            tick();
            if (c >= 2) begin
                int k;
                k = c - 2;
                checks++;
                if ({out_valid, out_sel, out} !== {1'b1, exp_sel[k], 8'(17 * exp_sel[k])}) begin
                    errors++;
                    $display("FAIL scan[%0d]: got valid=%b sel=%0d out=%h, want valid=1 sel=%0d out=%h",
                             k, out_valid, out_sel, out, exp_sel[k], 8'(17 * exp_sel[k]));
                end else $display("scan[%0d] ok sel=%0d out=%h", k, out_sel, out);
            end
        end
        mode = 1'b0; valid_in = 1'b0;
    endtask

    task automatic test_reset_midflight;
        valid_in = 1'b1;
        selector = 3'd1; tick();
        selector = 3'd3; tick();
        selector = 3'd7; tick();
        reset = 1'b1; valid_in = 1'b0;
        tick();
        reset = 1'b0;
        checks++;
        if ({out_valid, out_sel, out} !== 12'h000) begin
            errors++;
            $display("FAIL midreset: got valid=%b sel=%0d out=%h, want valid=0 sel=0 out=00", out_valid, out_sel, out);
        end else $display("midreset ok");
        valid_in = 1'b1; selector = 3'd3;
        for (int c = 1; c <= 3; c++) begin
            tick();
            valid_in = 1'b0;
            checks++;
            if (c < 3 ? (out_valid !== 1'b0) : ({out_valid, out_sel, out} !== {1'b1, 3'd3, 8'h33})) begin
                errors++;
                $display("FAIL postreset +%0d: got valid=%b sel=%0d out=%h, want valid=%b sel=3 out=33",
                         c, out_valid, out_sel, out, (c == 3));
            end else $display("postreset +%0d ok valid=%b out=%h", c, out_valid, out);
        end
    endtask

    initial begin
        reset = 1'b1; in_bus = '0; selector = '0; valid_in = 1'b0; en = 1'b1; mode = 1'b0;
        tick();
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_autoscan();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
